fp32_div_iter: RTL and testbench
================================

Name: fp32_div_iter

Overview:
- Iterative IEEE-754 single-precision divider (POUT = AIN / BIN); the inverse operation to the team's pipelined FP32 multiplier.
- Sits beside the multiplier in the FPU cluster and uses the same flag set (NaN, overflow, INF).
- Non-pipelined: a radix-2 restoring mantissa divide, one operation in flight, with a ready/valid input handshake.

Parameters:
- AWIDTH, 32, operand width; only 32 is supported.
- QBITS, 26, quotient bits generated (local, derived; not overridable).

Ports:
- CLK  input  1  clock
- NRST  input  1  reset, asynchronous, active-low
- AIN  input  AWIDTH  dividend, FP32
- BIN  input  AWIDTH  divisor, FP32
- DI_VALID  input  1  operand strobe
- DI_READY  output  1  high when IDLE; operands are accepted on DI_VALID && DI_READY
- DO_VALID  output  1  one-cycle result strobe
- POUT  output  AWIDTH  quotient
- NaN  output  1  result is NaN
- overflow  output  1  finite result exceeded the range
- INF  output  1  infinite operand produced an infinite result
- DIVZERO  output  1  finite nonzero / zero

Behaviour:
- Reset: state IDLE. POUT=0; NaN, overflow, INF, DIVZERO, DO_VALID = 0. DI_READY = 1 (decoded from IDLE).
- States: IDLE, ITER, NORM. There is no output-hold state.
- Flags and POUT are registered and hold until the next DO_VALID.
- Edge T (accept): capture signs, exponents and {1,mant} for A and B. Set the special-case code. Set rem = {0,mA}, count = 0. IDLE -> ITER. DI_READY is low from T.
- DI_VALID while DI_READY is low: ignored and dropped, no queueing.
- Edges T+1..T+26 (ITER), each iteration:
  - if rem >= {0,mB}: q bit = 1 and rem -= mB
  - rem <<= 1
  - count++
  - At count == 25: ITER -> NORM.
- Edge T+27 (NORM): round, register the result, pulse DO_VALID and return to IDLE.
  - Latency is 27 cycles; throughput is 1 per 27 cycles.
  - DI_READY is high in the same cycle as DO_VALID, and a new accept is allowed there.
- Normalise:
  - q[25]=1: mant = q[25:2], G = q[1], S = q[0] | (rem != 0), e = eA - eB + 127.
  - Else: mant = q[24:1], G = q[0], S = (rem != 0), e = eA - eB + 126.
  - Exponent arithmetic is 10-bit signed.
- Rounding: round-to-nearest-even; increment if G && (S || mant[0]). A mantissa carry-out sets mant = 0x800000 and e += 1.
- e >= 255: POUT = {sign, 0xFF, 0}, overflow = 1.
- e <= 0: flush to signed zero, no flag.
- Subnormal inputs (exponent 0) are treated as zero.
- Sign is sA ^ sB in all non-NaN results.
- Special cases, resolved in NORM and overriding the datapath, in priority order:
  - any NaN operand, 0/0 or inf/inf: POUT = 0xFFFFFFFF, NaN = 1
  - inf/finite: signed inf, INF = 1
  - finite/inf: signed zero
  - nonzero/0: signed inf, DIVZERO = 1
  - 0/nonzero: signed zero
- Exactly one flag is high per result; all flags are low for a normal result.
- NRST asserted mid-operation aborts the operation, returns to IDLE with reset values, and produces no DO_VALID.

Optional Feature:
- Macro FP32_DIV_EARLY_EXIT_EN.
- Defined: special-case operands go IDLE -> NORM directly at T. The result and DO_VALID appear at edge T+1 (latency 1), with identical result values.
- Undefined: every operation takes a fixed 27-cycle latency.

Decomposition:
- Package fp32_div_pkg:
  - EXP_BIAS = 127
  - QNAN = 32'hFFFFFFFF
  - MANT_W = 24
  - QBITS = 26
  - state enum {IDLE, ITER, NORM}
  - special-case code enum {SC_NONE, SC_NAN, SC_INF, SC_ZERO, SC_DIVZ}
- Sub-module fp32_div_mant_iter holds the rem/q shift registers, the compare/subtract step and the iteration counter. Its interface is start, done, q[25:0], rem_nz.

Test Plan:
- 0x40C00000 / 0x40000000 accepted at T -> DO_VALID only at T+27, POUT = 0x40400000, all flags 0.
- 0x3F800000 / 0x40400000 -> POUT = 0x3EAAAAAB (round-up path).
- 0x3F800000 / 0x00000000 -> POUT = 0x7F800000, DIVZERO = 1. Then 0x00000000 / 0x00000000 -> POUT = 0xFFFFFFFF, NaN = 1.
- 0x7F000000 / 0x00800000 -> POUT = 0x7F800000, overflow = 1. 0xFF800000 / 0x40000000 -> POUT = 0xFF800000, INF = 1.
- Second DI_VALID at T+5 (DI_READY = 0) -> dropped; a single DO_VALID at T+27. A back-to-back accept in the DO_VALID cycle -> next DO_VALID 27 cycles later.
- NRST pulsed at T+10 -> no DO_VALID, outputs 0, DI_READY = 1. With FP32_DIV_EARLY_EXIT_EN, 0x7FC00000 / 0x3F800000 -> NaN at T+1.

Source files
------------

// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the iterative FP32 divider.
// Holds the FSM states, special-case codes and format constants.
package fp32_div_pkg;

  localparam int EXP_BIAS = 127;
  localparam logic [31:0] QNAN = 32'hFFFFFFFF;
  localparam int MANT_W = 24;
  localparam int QBITS = 26;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    NORM
  } state_t;

  typedef enum logic [2:0] {
    SC_NONE,
    SC_NAN,
    SC_INF,
    SC_ZERO,
    SC_DIVZ
  } sc_t;

endpackage

// File: rtl/fp32_div_mant_iter.sv
// Radix-2 restoring mantissa divider, one quotient bit per cycle.
// Ports: CLK, NRST, start (load ma/mb), done (last step), q, rem_nz.
module fp32_div_mant_iter
  import fp32_div_pkg::*;
(
  input  logic              CLK,
  input  logic              NRST,
  input  logic              start,
  input  logic [MANT_W-1:0] ma,
  input  logic [MANT_W-1:0] mb,
  output logic              done,
  output logic [QBITS-1:0]  q,
  output logic              rem_nz
);

  logic [MANT_W:0]   rem;
  logic [MANT_W:0]   diff;
  logic [MANT_W-1:0] mb_q;
  logic [4:0]        count;
  logic              run;
  logic              ge;

  assign ge     = rem >= {1'b0, mb_q};
  assign diff   = ge ? rem - {1'b0, mb_q} : rem;
  assign done   = run && (count == 5'(QBITS - 1));
  assign rem_nz = |rem;

  // After a subtract the remainder is below mb, so the
  // left shift never loses a set bit.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rem   <= '0;
      mb_q  <= '0;
      q     <= '0;
      count <= '0;
      run   <= 1'b0;
    end else if (start) begin
      rem   <= {1'b0, ma};
      mb_q  <= mb;
      q     <= '0;
      count <= '0;
      run   <= 1'b1;
    end else if (run) begin
      q     <= {q[QBITS-2:0], ge};
      rem   <= diff << 1;
      count <= count + 5'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fp32_div_iter.sv
// Iterative FP32 divider POUT = AIN / BIN, ready/valid input, 27-cycle latency.
// Ports: CLK, NRST, AIN, BIN, DI_VALID/DI_READY, DO_VALID, POUT, NaN, overflow,
// INF, DIVZERO. FP32_DIV_EARLY_EXIT_EN: special operands finish in 1 cycle.
module fp32_div_iter
  import fp32_div_pkg::*;
#(
  parameter int AWIDTH = 32
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [AWIDTH-1:0] AIN,
  input  logic [AWIDTH-1:0] BIN,
  input  logic              DI_VALID,
  output logic              DI_READY,
  output logic              DO_VALID,
  output logic [AWIDTH-1:0] POUT,
  output logic              NaN,
  output logic              overflow,
  output logic              INF,
  output logic              DIVZERO
);

  state_t state, state_n;
  sc_t    sc_in, sc_q;

  logic       s_q;
  logic [7:0] ea_q, eb_q;
  logic       accept, done, rem_nz;
  logic [QBITS-1:0] q;

  logic [7:0] ea, eb;
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;

  assign ea = AIN[30:23];
  assign eb = BIN[30:23];
  assign a_nan  = (&ea) && (|AIN[22:0]);
  assign a_inf  = (&ea) && !(|AIN[22:0]);
  assign a_zero = (ea == 8'd0);
  assign b_nan  = (&eb) && (|BIN[22:0]);
  assign b_inf  = (&eb) && !(|BIN[22:0]);
  assign b_zero = (eb == 8'd0);

  assign DI_READY = (state == IDLE);
  assign accept   = DI_VALID && DI_READY;

  always_comb begin
    sc_in = SC_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      sc_in = SC_NAN;
    else if (a_inf)
      sc_in = SC_INF;
    else if (b_inf)
      sc_in = SC_ZERO;
    else if (b_zero)
      sc_in = SC_DIVZ;
    else if (a_zero)
      sc_in = SC_ZERO;
  end

  fp32_div_mant_iter u_mant (
    .CLK    (CLK),
    .NRST   (NRST),
    .start  (accept),
    .ma     ({1'b1, AIN[22:0]}),
    .mb     ({1'b1, BIN[22:0]}),
    .done   (done),
    .q      (q),
    .rem_nz (rem_nz)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef FP32_DIV_EARLY_EXIT_EN
          state_n = (sc_in != SC_NONE) ? NORM : ITER;
`else
          state_n = ITER;
`endif
        end
      end
      ITER: if (done) state_n = NORM;
      NORM: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s_q  <= 1'b0;
      ea_q <= '0;
      eb_q <= '0;
      sc_q <= SC_NONE;
    end else if (accept) begin
      s_q  <= AIN[31] ^ BIN[31];
      ea_q <= ea;
      eb_q <= eb;
      sc_q <= sc_in;
    end
  end

  logic [23:0] mant;
  logic [22:0] frac;
  logic [9:0]  e_base, e_fin;
  logic        g, st, rnd_up, carry;
  logic [31:0] res;
  logic        r_nan, r_ovf, r_inf, r_dz;

  // Exponent is kept as 10-bit two's complement so that
  // underflow (bit 9 set) and overflow are both visible.
  always_comb begin
    if (q[QBITS-1]) begin
      mant = q[25:2];
      g    = q[1];
      st   = q[0] | rem_nz;
    end else begin
      mant = q[24:1];
      g    = q[0];
      st   = rem_nz;
    end
    rnd_up = g & (st | mant[0]);
    carry  = rnd_up & (&mant);
    frac   = mant[22:0] + 23'(rnd_up);
    e_base = {2'b00, ea_q} - {2'b00, eb_q} + 10'(EXP_BIAS)
           - {9'd0, ~q[QBITS-1]};
    e_fin  = carry ? e_base + 10'd1 : e_base;

    res   = {s_q, e_fin[7:0], frac};
    r_nan = 1'b0;
    r_ovf = 1'b0;
    r_inf = 1'b0;
    r_dz  = 1'b0;
    unique case (sc_q)
      SC_NAN: begin
        res   = QNAN;
        r_nan = 1'b1;
      end
      SC_INF: begin
        res   = {s_q, 8'hFF, 23'd0};
        r_inf = 1'b1;
      end
      SC_ZERO: res = {s_q, 31'd0};
      SC_DIVZ: begin
        res  = {s_q, 8'hFF, 23'd0};
        r_dz = 1'b1;
      end
      default: begin
        if (!e_fin[9] && (e_fin >= 10'd255)) begin
          res   = {s_q, 8'hFF, 23'd0};
          r_ovf = 1'b1;
        end else if (e_fin[9] || (e_fin == 10'd0)) begin
          res = {s_q, 31'd0};
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      DO_VALID <= 1'b0;
      POUT     <= '0;
      NaN      <= 1'b0;
      overflow <= 1'b0;
      INF      <= 1'b0;
      DIVZERO  <= 1'b0;
    end else begin
      DO_VALID <= 1'b0;
      if (state == NORM) begin
        DO_VALID <= 1'b1;
        POUT     <= res;
        NaN      <= r_nan;
        overflow <= r_ovf;
        INF      <= r_inf;
        DIVZERO  <= r_dz;
      end
    end
  end

endmodule

// File: tb/tb_fp32_div_iter.sv
// Directed self-checking bench for fp32_div_iter.
// Vector table plus drop, back-to-back and mid-op reset sequences.
module tb_fp32_div_iter;

`ifdef FP32_DIV_EARLY_EXIT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 27;
`endif

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [31:0] AIN = '0;
  logic [31:0] BIN = '0;
  logic        DI_VALID = 1'b0;
  logic        DI_READY, DO_VALID;
  logic [31:0] POUT;
  logic        NaN, overflow, INF, DIVZERO;

  int tests = 0;
  int fails = 0;

  fp32_div_iter dut (
    .CLK      (CLK),
    .NRST     (NRST),
    .AIN      (AIN),
    .BIN      (BIN),
    .DI_VALID (DI_VALID),
    .DI_READY (DI_READY),
    .DO_VALID (DO_VALID),
    .POUT     (POUT),
    .NaN      (NaN),
    .overflow (overflow),
    .INF      (INF),
    .DIVZERO  (DIVZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  f;
    bit          sp;
  } vec_t;

  // flag nibble order: {NaN, overflow, INF, DIVZERO}
  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called just after a posedge with DI_READY high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] p, output logic [3:0] f,
                       output int lat);
    AIN = a;
    BIN = b;
    DI_VALID = 1'b1;
    @(posedge CLK); #1;
    DI_VALID = 1'b0;
    lat = 0;
    while (!DO_VALID && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    p = POUT;
    f = {NaN, overflow, INF, DIVZERO};
  endtask

  initial begin
    logic [31:0] p;
    logic [3:0]  f;
    int lat, pulses, first;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 0};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 0};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0010, 1};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[7]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1};
    vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1};
    vecs[9]  = '{32'hC0E00000, 32'h40000000, 32'hC0600000, 4'b0000, 0};
    vecs[10] = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0000, 0};
    vecs[11] = '{32'h7F800000, 32'h7F800000, 32'hFFFFFFFF, 4'b1000, 1};
    vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 0};
    vecs[13] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 0};
    vecs[14] = '{32'h3F800000, 32'h40E00000, 32'h3E124925, 4'b0000, 0};
    vecs[15] = '{32'h3F800000, 32'h40A00000, 32'h3E4CCCCD, 4'b0000, 0};
    vecs[16] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1};
    vecs[17] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1};
    vecs[18] = '{32'hBF800000, 32'h00400000, 32'hFF800000, 4'b0001, 1};
    vecs[19] = '{32'h40000000, 32'hC0800000, 32'hBF000000, 4'b0000, 0};

    repeat (2) @(posedge CLK);
    @(negedge CLK) NRST = 1'b1;
    @(posedge CLK); #1;
    chk("reset_pout", POUT, 32'h0);
    chk("reset_flags", 32'({NaN, overflow, INF, DIVZERO}), 32'h0);
    chk("reset_dovalid", 32'(DO_VALID), 32'h0);
    chk("reset_diready", 32'(DI_READY), 32'h1);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, p, f, lat);
      chk($sformatf("v%0d_pout", i), p, vecs[i].p);
      chk($sformatf("v%0d_flags", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("v%0d_lat", i), 32'(lat),
          vecs[i].sp ? 32'(SP_LAT) : 32'd27);
    end

    // back-to-back: accept in the DO_VALID cycle
    chk("b2b_ready", 32'(DI_READY), 32'h1);
    do_op(32'h40C00000, 32'h40000000, p, f, lat);
    chk("b2b_lat", 32'(lat), 32'd27);
    chk("b2b_pout", p, 32'h40400000);

    // drop: second strobe while busy is ignored
    AIN = 32'h40C00000;
    BIN = 32'h40000000;
    DI_VALID = 1'b1;
    @(posedge CLK); #1;
    DI_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    AIN = 32'h3F800000;
    BIN = 32'h40400000;
    DI_VALID = 1'b1;
    chk("drop_ready_low", 32'(DI_READY), 32'h0);
    @(posedge CLK); #1;
    DI_VALID = 1'b0;
    pulses = 0;
    first = 0;
    p = '0;
    for (int k = 6; k <= 70; k++) begin
      @(posedge CLK); #1;
      if (DO_VALID) begin
        pulses++;
        if (first == 0) begin
          first = k;
          p = POUT;
        end
      end
    end
    chk("drop_pulses", 32'(pulses), 32'd1);
    chk("drop_lat", 32'(first), 32'd27);
    chk("drop_pout", p, 32'h40400000);

    // mid-operation reset
    AIN = 32'h3F800000;
    BIN = 32'h40400000;
    DI_VALID = 1'b1;
    @(posedge CLK); #1;
    DI_VALID = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK) NRST = 1'b0;
    #1;
    chk("rst_pout", POUT, 32'h0);
    chk("rst_diready", 32'(DI_READY), 32'h1);
    chk("rst_dovalid", 32'(DO_VALID), 32'h0);
    @(negedge CLK) NRST = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (DO_VALID) pulses++;
    end
    chk("rst_no_dovalid", 32'(pulses), 32'd0);
    chk("rst_idle", 32'(DI_READY), 32'h1);

    // still functional after the abort
    do_op(32'h3F800000, 32'h40400000, p, f, lat);
    chk("post_rst_pout", p, 32'h3EAAAAAB);
    chk("post_rst_lat", 32'(lat), 32'd27);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
